// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-controller slave.
// Optional parity storage is enabled by defining MEM_CTRL_PARITY_EN.
package mem_ctrl_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] OOR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/mem_ctrl_sram.sv
// Single-port synchronous word array; read data registers on the access edge.
// Parity storage exists only when MEM_CTRL_PARITY_EN is defined.
module mem_ctrl_sram
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
`ifdef MEM_CTRL_PARITY_EN
  ,
  input  logic                  i_wpar,
  output logic                  o_rpar
`endif
);
  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

`ifdef MEM_CTRL_PARITY_EN
  logic r_par [2**DEPTH_LOG2];
  logic r_rpar;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_par[i_addr] <= i_wpar;
      else      r_rpar        <= r_par[i_addr];
    end
  end

  assign o_rpar = r_rpar;
`endif
endmodule

// File: rtl/mem_ctrl_slave.sv
// DMA-facing memory slave: IDLE -> ACCESS (wait states) -> RESP ack pulse.
// Define MEM_CTRL_PARITY_EN to store and check an even-parity bit per word.
module mem_ctrl_slave
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_req,
  input  logic              dma_rw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              busy,
  output logic              addr_err,
  output logic              parity_err
);
  localparam logic [3:0] LAST =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack;
  logic              r_oor;

  logic              w_take;
  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_range;
  logic              w_go;
  logic [DATA_W-1:0] w_rdata;

  // With zero wait states the array is hit on the accept edge itself,
  // so the live inputs must bypass the latches.
  assign w_take  = (r_state == ST_IDLE) && dma_req;
  assign w_rw    = w_take ? dma_rw    : r_rw;
  assign w_addr  = w_take ? dma_addr  : r_addr;
  assign w_wdata = w_take ? dma_wdata : r_wdata;
  assign w_in_range = (w_addr[ADDR_W-1:DEPTH_LOG2] == '0);
  assign w_go = (w_take && (WAIT_CYCLES == 0)) ||
                ((r_state == ST_ACCESS) && (r_cnt == LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_ack <= w_go;
      r_oor <= w_go && !w_in_range;
      unique case (r_state)
        ST_IDLE: begin
          if (dma_req) begin
            r_rw    <= dma_rw;
            r_addr  <= dma_addr;
            r_wdata <= dma_wdata;
            r_cnt   <= '0;
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == LAST) r_state <= ST_RESP;
          else               r_cnt   <= r_cnt + 4'd1;
        end
        ST_RESP: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_CTRL_PARITY_EN
  logic w_wpar;
  logic w_rpar;
  assign w_wpar = even_par(w_wdata);
`endif

  mem_ctrl_sram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk    (clk),
    .i_en   (w_go && w_in_range),
    .i_we   (w_rw),
    .i_addr (w_addr[DEPTH_LOG2-1:0]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
`ifdef MEM_CTRL_PARITY_EN
    ,
    .i_wpar (w_wpar),
    .o_rpar (w_rpar)
`endif
  );

  assign dma_ack  = r_ack;
  assign busy     = (r_state != ST_IDLE);
  assign addr_err = r_ack && r_oor;
  assign dma_rdata = (!r_ack || r_rw) ? '0 :
                     r_oor ? OOR_RDATA : w_rdata;

`ifdef MEM_CTRL_PARITY_EN
  assign parity_err = r_ack && !r_rw && !r_oor &&
                      (even_par(w_rdata) != w_rpar);
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_ctrl_slave.sv
// Self-checking bench for mem_ctrl_slave (default and zero-wait instances).
// Parity corruption check runs only when MEM_CTRL_PARITY_EN is defined.
module tb_mem_ctrl_slave;
  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, rw;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic        ack, busy, aerr, perr;
  logic [31:0] rdata;

  logic        q_req, q_rw;
  logic [21:0] q_addr;
  logic [31:0] q_wdata;
  logic        q_ack, q_busy, q_aerr, q_perr;
  logic [31:0] q_rdata;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem_m [1024];
  bit          wr_m  [1024];

  always #5 clk = ~clk;

  mem_ctrl_slave #(.WAIT_CYCLES(WAIT), .DEPTH_LOG2(10)) u0 (
    .clk(clk), .reset(reset),
    .dma_req(req), .dma_rw(rw),
    .dma_addr(addr), .dma_wdata(wdata),
    .dma_ack(ack), .dma_rdata(rdata),
    .busy(busy), .addr_err(aerr),
    .parity_err(perr)
  );

  mem_ctrl_slave #(.WAIT_CYCLES(0), .DEPTH_LOG2(10)) u1 (
    .clk(clk), .reset(reset),
    .dma_req(q_req), .dma_rw(q_rw),
    .dma_addr(q_addr), .dma_wdata(q_wdata),
    .dma_ack(q_ack), .dma_rdata(q_rdata),
    .busy(q_busy), .addr_err(q_aerr),
    .parity_err(q_perr)
  );

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  function automatic bit dma_ack_now();
    return ack;
  endfunction

  task automatic access(input bit a_rw, input logic [21:0] a,
                        input logic [31:0] d, input bit drop,
                        input bit exp_perr);
    int  n;
    bit  got;
    bit  oor;
    int  idx;
    oor = (a[21:10] != 12'd0);
    idx = int'(a[9:0]);
    @(negedge clk);
    req = 1'b1; rw = a_rw; addr = a; wdata = d;
    @(posedge clk);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (dma_ack_now()) got = 1'b1;
      if (n == 1) begin
        if (drop) req = 1'b0;
        rw = 1'($urandom);
        addr = 22'($urandom);
        wdata = $urandom;
        if (!got) begin
          chk("busy_wait", 32'(busy), 32'd1);
          chk("rdata_wait", rdata, 32'h0);
        end
      end
    end
    chk("ack_latency", 32'(n), 32'(WAIT + 1));
    chk("addr_err", 32'(aerr), 32'(oor));
    chk("parity_err", 32'(perr), 32'(exp_perr));
    if (a_rw)
      chk("wr_rdata", rdata, 32'h0);
    else if (oor)
      chk("oor_rdata", rdata, 32'hDEAD_BEEF);
    else if (wr_m[idx])
      chk("rd_data", rdata, mem_m[idx]);
    if (a_rw && !oor) begin
      mem_m[idx] = d;
      wr_m[idx] = 1'b1;
    end
    req = 1'b0;
    @(negedge clk);
    chk("ack_single", 32'(ack), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [21:0] ra;
    bit          rrw;
    for (int i = 0; i < 1024; i++) wr_m[i] = 1'b0;
    reset = 1'b1;
    req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    q_req = 1'b0; q_rw = 1'b0; q_addr = '0; q_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_aerr", 32'(aerr), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    reset = 1'b0;

    access(1'b1, 22'h000003, 32'hCAFE_CAFE, 1'b0, 1'b0);
    access(1'b0, 22'h000003, 32'h0, 1'b0, 1'b0);
    chk("cafe_direct", mem_m[3], 32'hCAFE_CAFE);

    access(1'b1, 22'h000000, 32'h1111_2222, 1'b0, 1'b0);
    access(1'b1, 22'h000400, 32'h5555_6666, 1'b0, 1'b0);
    access(1'b0, 22'h000400, 32'h0, 1'b0, 1'b0);
    access(1'b0, 22'h000000, 32'h0, 1'b0, 1'b0);

    access(1'b1, 22'h000010, 32'h1234_5678, 1'b1, 1'b0);
    access(1'b0, 22'h000010, 32'h0, 1'b0, 1'b0);

    access(1'b1, 22'h000005, 32'h0BAD_F00D, 1'b0, 1'b0);
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = 22'h000005; wdata = 32'h9999_AAAA;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    req = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_aerr", 32'(aerr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_ack", 32'(ack), 32'd0);
    end
    reset = 1'b0;
    access(1'b0, 22'h000005, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rrw = 1'($urandom);
      if ($urandom_range(0, 7) == 0)
        ra = {12'($urandom_range(1, 4095)), 10'($urandom)};
      else
        ra = 22'($urandom_range(0, 31));
      access(rrw, ra, $urandom, 1'($urandom), 1'b0);
    end

`ifdef MEM_CTRL_PARITY_EN
    access(1'b1, 22'h000020, 32'h0F0F_0F0F, 1'b0, 1'b0);
    u0.u_sram.r_mem[32][3] = ~u0.u_sram.r_mem[32][3];
    mem_m[32] = 32'h0F0F_0F07;
    access(1'b0, 22'h000020, 32'h0, 1'b0, 1'b1);
`endif

    @(negedge clk);
    q_req = 1'b1; q_rw = 1'b1; q_addr = 22'h000007;
    q_wdata = 32'hA5A5_5A5A;
    @(posedge clk);
    @(negedge clk);
    chk("w0_wr_ack", 32'(q_ack), 32'd1);
    chk("w0_wr_rdata", q_rdata, 32'h0);
    q_rw = 1'b0;
    @(negedge clk);
    chk("w0_gap_busy", 32'(q_busy), 32'd0);
    chk("w0_gap_ack", 32'(q_ack), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("w0_rd_ack", 32'(q_ack), 32'd1);
    chk("w0_rd_data", q_rdata, 32'hA5A5_5A5A);
    chk("w0_rd_aerr", 32'(q_aerr), 32'd0);
    chk("w0_rd_perr", 32'(q_perr), 32'd0);
    q_req = 1'b0;
    @(negedge clk);
    chk("w0_end_ack", 32'(q_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_slave.md
MEM_CTRL_SLAVE -- requirements
Module: mem_ctrl_slave

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and acknowledge (legal range 0..15).
REQ-002 Parameter DEPTH_LOG2, default 10: log2 of the on-chip word count (1024 x 32 words).
REQ-003 Port clk, input, 1: single clock; every register updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port dma_req, input, 1: initiator request, held high until acknowledged.
REQ-006 Port dma_rw, input, 1: direction, 0 = read, 1 = write.
REQ-007 Port dma_addr, input, 22: word address.
REQ-008 Port dma_wdata, input, 32: write data.
REQ-009 Port dma_ack, output, 1: single-cycle completion pulse.
REQ-010 Port dma_rdata, output, 32: read data, valid only while dma_ack=1.
REQ-011 Port busy, output, 1: high in any state other than IDLE.
REQ-012 Port addr_err, output, 1: pulses with dma_ack when the completed access was out of range.
REQ-013 Port parity_err, output, 1: pulses with dma_ack on a read parity mismatch; tied to 0 when parity is disabled.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP.
REQ-015 In IDLE with dma_req=1, the block latches dma_rw, dma_addr and dma_wdata at the clock edge; it enters ACCESS if WAIT_CYCLES>0, otherwise RESP.
REQ-016 ACCESS counts WAIT_CYCLES cycles with a 4-bit counter, then enters RESP; latency from request-sampling edge to dma_ack high = WAIT_CYCLES+1 cycles.
REQ-017 RESP lasts exactly one cycle with dma_ack=1, then returns unconditionally to IDLE; back-to-back requests therefore take at least WAIT_CYCLES+2 cycles each.
REQ-018 A write commits to the array on the edge entering RESP; a read loads dma_rdata from the array on that same edge.
REQ-019 dma_rdata=0 whenever dma_ack=0 and for every write acknowledge.
REQ-020 Address in range iff dma_addr[21:DEPTH_LOG2]==0; array index = dma_addr[DEPTH_LOG2-1:0].
REQ-021 Out-of-range write: array unchanged; dma_ack and addr_err both pulse.
REQ-022 Out-of-range read: dma_rdata=32'hDEAD_BEEF; dma_ack and addr_err both pulse.
REQ-023 dma_req dropping while in ACCESS does not abort the access: the latched transaction completes and dma_ack still pulses.
REQ-024 Input changes after acceptance are ignored until the block returns to IDLE.
REQ-025 dma_req high while busy is not sampled; the request is accepted on the first IDLE cycle.

Reset
REQ-026 While reset=1: state=IDLE, counter=0, dma_ack=0, dma_rdata=0, busy=0, addr_err=0, parity_err=0.
REQ-027 Reset asserted mid-access discards the pending transaction (no array write, no ack); array contents are not reset.

Configuration
REQ-028 With macro MEM_CTRL_PARITY_EN defined, each word stores an even-parity bit computed on write; a read mismatch raises parity_err together with dma_ack, and the data is still returned.
REQ-029 Without MEM_CTRL_PARITY_EN, no parity storage is built and parity_err is constant 0.

Structure
REQ-030 Package mem_ctrl_pkg holds ADDR_W=22, DATA_W=32, the state enum, and OOR_RDATA=32'hDEAD_BEEF.
REQ-031 Sub-module mem_ctrl_sram is a single-port synchronous array (we, addr, wdata, rdata, plus an optional parity bit); the FSM stays in mem_ctrl_slave.

Verification
REQ-032 Write 32'hCAFE_CAFE to address 0x000003, then read 0x000003 -> each ack arrives 3 cycles after the request edge; the read returns 32'hCAFE_CAFE.
REQ-033 With WAIT_CYCLES=0, a write immediately followed by a read -> ack 1 cycle after each request; busy low for at least 1 cycle between the two accesses.
REQ-034 Write to 0x000400, then read 0x000400 -> addr_err pulses on both acks; the read returns 32'hDEAD_BEEF; address 0x000000 is unchanged.
REQ-035 dma_req dropped 1 cycle after acceptance of a write of 32'h1234_5678 to 0x000010 -> ack still pulses; a later read returns 32'h1234_5678.
REQ-036 reset asserted during ACCESS of a write of 32'h9999_AAAA to 0x000005 -> no ack is produced and all outputs read 0; a later read returns the old contents.
REQ-037 With MEM_CTRL_PARITY_EN, force one stored bit of a written word to flip, then read that word -> parity_err=1 together with dma_ack.
